// File: rtl/integral_window_builder.sv
// integral_window_builder: 20x20 integral image of one window from a pixel stream; INTEGRAL_SQSUM_EN adds the squared-pixel sum.
module integral_window_builder #(
  parameter int WIN_W = 20,
  parameter int WIN_H = 20
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  pixel,
  input  logic        pixel_valid,
  input  logic        pixel_sof,
  output logic        pixel_ready,
  input  logic        NEXT,
  output logic        START,
  output logic [31:0] integral_buffer [WIN_W*WIN_H],
  output logic [31:0] sq_total
);
  localparam int N  = WIN_W * WIN_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(WIN_W);
  localparam int YW = $clog2(WIN_H);
  localparam int IW = $clog2(255 * N + 1);
  typedef enum logic {FILL, DONE} state_t;
  state_t state, state_nx;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [IW-1:0] rs, rs_new, above, ii;
  logic [AW-1:0] idx;
  logic acc, x_end, y_end;
  assign acc    = pixel_valid && pixel_ready;
  assign px     = pixel_sof ? '0 : x;
  assign py     = pixel_sof ? '0 : y;
  assign x_end  = px == XW'(WIN_W - 1);
  assign y_end  = py == YW'(WIN_H - 1);
  assign idx    = AW'(py) * AW'(WIN_W) + AW'(px);
  assign rs_new = (px == '0 ? '0 : rs) + IW'(pixel);
  assign above  = py == '0 ? '0 : integral_buffer[idx - AW'(WIN_W)][IW-1:0];
  assign ii     = rs_new + above;
  always_comb begin
    pixel_ready = state == FILL && !Reset;
    START       = state == DONE;
    state_nx    = (state == FILL && pixel_valid && x_end && y_end) ? DONE :
                  (state == DONE && NEXT) ? FILL : state;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FILL;
      x     <= '0;
      y     <= '0;
      rs    <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        x  <= x_end ? '0 : px + 1'b1;
        y  <= x_end ? (y_end ? '0 : py + 1'b1) : py;
        rs <= rs_new;
      end else if (state == DONE && NEXT) begin
        x  <= '0;
        y  <= '0;
        rs <= '0;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) integral_buffer[i] <= '0;
    end else if (acc) begin
      integral_buffer[idx] <= 32'(ii);
    end
  end
`ifdef INTEGRAL_SQSUM_EN
  localparam int SW = $clog2(255 * 255 * N + 1);
  logic [SW-1:0] sq_acc;
  logic [15:0]   sq_px;
  assign sq_px = 16'(pixel) * 16'(pixel);
  always_ff @(posedge Clk) begin
    if (Reset) sq_acc <= '0;
    else if (acc) sq_acc <= ((px == '0 && py == '0) ? '0 : sq_acc) + SW'(sq_px);
  end
  assign sq_total = 32'(sq_acc);
`else
  assign sq_total = '0;
`endif
endmodule

// File: doc/integral_window_builder.md
# integral_window_builder

- Builds the 20×20 integral image of one detection window from a raster-ordered 8-bit pixel stream.
- Presents it as a 400-entry array of 32-bit values with a START level, in the exact layout the Haar cascade comparison stage reads (`integral_buffer[y*20+x]`).
- Holds the completed window frozen until the downstream stage releases it with NEXT, then refills.
- Sits between the camera/pixel fetch path and the cascade comparator.

## Interface

Parameters:
- WIN_W, 20, window width in pixels
- WIN_H, 20, window height in pixels (array depth = WIN_W*WIN_H = 400)

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- pixel  in  8  unsigned grayscale pixel
- pixel_valid  in  1  pixel is presented this cycle
- pixel_sof  in  1  qualifies pixel as window position (0,0); sampled only when pixel_valid
- pixel_ready  out  1  builder accepts a pixel this cycle
- NEXT  in  1  downstream releases the completed window
- START  out  1  integral_buffer holds a complete, stable window
- integral_buffer  out  [31:0] ×400  unpacked array; entry y*WIN_W+x = integral value at (x,y)
- sq_total  out  32  sum of squared pixels of the window (only with INTEGRAL_SQSUM_EN)

## Operation

- Definition: ii(x,y) = sum of pixel(i,j) for i≤x, j≤y.
- Accept: a pixel is taken on any cycle where pixel_valid && pixel_ready.
- Internal counters: column x (0..WIN_W-1), row y (0..WIN_H-1), row running sum rs (17 bits).
- Per accepted pixel at (x,y):
  - rs_new = (x==0 ? 0 : rs) + pixel.
  - ii(x,y) = rs_new + (y==0 ? 0 : integral_buffer[(y-1)*WIN_W+x]).
  - Write ii(x,y) into the entry, zero-extended to 32 bits; advance x.
  - When x wraps to 0, advance y.
- Width: maximum value is 255*400 = 102000, which fits in 17 bits. Upper 15 bits of every entry are always 0.
- States:
  - FILL: pixel_ready=1, START=0. On acceptance of position (WIN_W-1, WIN_H-1), go to DONE.
  - DONE: pixel_ready=0, START=1, buffer and sq_total frozen. NEXT=1 → FILL with x=y=0, rs=0.
- pixel_sof accepted in FILL at any position: that pixel is treated as (0,0) and counters restart. This is the resync case.
- pixel_sof=0 on the first pixel after reset/NEXT: the pixel is still taken as (0,0). Position is purely by count.
- NEXT in FILL: ignored.
- Stale data: buffer entries are not cleared on NEXT. Stale entries remain until overwritten, and START=0 marks them invalid.
- Reset (any state, including mid-window):
  - State → FILL, x=y=0, rs=0.
  - All 400 entries → 0, sq_total → 0, START → 0.
  - pixel_ready → 0 during the Reset cycle, 1 the first cycle after.

## Timing

- Throughput: one pixel per cycle; valid gaps are allowed and hold all state.
- Write latency: an entry written by a pixel accepted in cycle N is visible on integral_buffer in cycle N+1.
- Window completion:
  - Last pixel accepted in cycle N → START=1 and pixel_ready=0 in cycle N+1, with all 400 entries final.
  - Minimum 400 cycles from the first accepted pixel to START.
- Release: NEXT sampled high in cycle M while in DONE → START=0 and pixel_ready=1 in cycle M+1.
- Simultaneous NEXT and pixel_valid in DONE: the pixel is not accepted, because pixel_ready=0 that cycle.
- Upstream must hold pixel, pixel_valid and pixel_sof stable until accepted.

## Configuration

- INTEGRAL_SQSUM_EN defined:
  - An accumulator adds pixel*pixel (16 bits) per accepted pixel; max 26010000, 25 bits, driven zero-extended on sq_total.
  - Cleared when (0,0) is accepted (the position after reset/NEXT, or any pixel_sof pixel), and by Reset.
  - Frozen in DONE.
- INTEGRAL_SQSUM_EN undefined: no accumulator or multiplier; sq_total is tied to 0.

## Test plan

- All pixels = 1, back-to-back valid → every entry = (x+1)(y+1), entry 399 = 400. START rises exactly the cycle after the 400th acceptance.
- Pixel = x (column ramp) → entry 19 = 190, entry 399 = 3800. With INTEGRAL_SQSUM_EN, sq_total = 49400.
- All pixels = 255 with pixel_valid toggled every other cycle → entry 399 = 102000, upper 15 bits 0. START appears after 400 acceptances, not after 400 cycles. With the macro, sq_total = 26010000.
- 150 pixels of value 7, then pixel_sof with value 2, followed by 399 pixels of value 2 → entry 399 = 800, entry 0 = 2.
- In DONE, drive pixel_valid=1 and NEXT=1 in the same cycle → that pixel is not accepted, START=0 next cycle. The next 400 pixels of value 3 → entry 399 = 1200.
- Reset asserted after 200 pixels → next cycle all entries 0, START=0, pixel_ready=1. The following 400 ones → entry 399 = 400.
